// File: rtl/rv32i_rvfi_pkg.sv
// Shared types for the RVFI retirement trace buffer: packet layout,
// occupancy states and the capture/sanitise helper.
package rv32i_rvfi_pkg;

  localparam int unsigned OrderW = 64;

  typedef struct packed {
    logic [OrderW-1:0] order;
    logic [31:0]       pc;
    logic [31:0]       nxt_pc;
    logic [31:0]       insn;
    logic              trap;
    logic              intr;
    logic [1:0]        mode;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_wdata;
    logic [31:0]       mem_addr;
    logic [3:0]        mem_rmask;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;
    logic [31:0]       mem_wdata;
  } rvfi_pkt_t;

  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_state_e;

  // Build a packet from raw retirement signals. A trapped instruction did not
  // write rd nor complete its memory access, and x0 writes are not reported.
  function automatic rvfi_pkt_t rvfi_pack(
    input logic [OrderW-1:0] order,
    input logic [31:0]       pc,
    input logic [31:0]       nxt_pc,
    input logic [31:0]       insn,
    input logic              trap,
    input logic              intr,
    input logic [1:0]        mode,
    input logic [4:0]        rd_addr,
    input logic [31:0]       rd_wdata,
    input logic              rd_we,
    input logic [31:0]       mem_addr,
    input logic [3:0]        mem_rmask,
    input logic [3:0]        mem_wmask,
    input logic [31:0]       mem_rdata,
    input logic [31:0]       mem_wdata
  );
    rvfi_pkt_t p;
    logic      rd_kill;
    rd_kill     = trap || !rd_we || (rd_addr == 5'd0);
    p.order     = order;
    p.pc        = pc;
    p.nxt_pc    = nxt_pc;
    p.insn      = insn;
    p.trap      = trap || intr;
    p.intr      = intr;
    p.mode      = mode;
    p.rd_addr   = rd_kill ? 5'd0 : rd_addr;
    p.rd_wdata  = rd_kill ? 32'd0 : rd_wdata;
    p.mem_addr  = mem_addr;
    p.mem_rmask = trap ? 4'd0 : mem_rmask;
    p.mem_wmask = trap ? 4'd0 : mem_wmask;
    p.mem_rdata = mem_rdata;
    p.mem_wdata = mem_wdata;
    return p;
  endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pointers wrap at DEPTH (power of
// two); full/empty come from the separate count.
module rv32i_sync_fifo
  import rv32i_rvfi_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  occ_state_e       occ;
  logic             push_en, pop_en;

  // Occupancy decode and accepted push/pop.
  always_comb begin
    if (count_q == '0) begin
      occ = OccEmpty;
    end else if (count_q == CntW'(DEPTH)) begin
      occ = OccFull;
    end else begin
      occ = OccPartial;
    end
    pop_en  = pop && (occ != OccEmpty);
    push_en = push && ((occ != OccFull) || pop_en);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  // Head entry and status outputs.
  always_comb begin
    empty = (occ == OccEmpty);
    full  = (occ == OccFull);
    count = count_q;
    rdata = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/rv32i_rvfi_trace_buf.sv
// Retirement trace buffer: stamps each retired/trapped instruction with an
// order number, queues it, and drains it over valid/ready.
module rv32i_rvfi_trace_buf
  import rv32i_rvfi_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ORDER_W = 64,
  localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ret_valid,
  input  logic [31:0]        ret_pc,
  input  logic [31:0]        ret_nxt_pc,
  input  logic [31:0]        ret_insn,
  input  logic               ret_trap,
  input  logic               ret_intr,
  input  logic [1:0]         ret_mode,
  input  logic [4:0]         ret_rd_addr,
  input  logic [31:0]        ret_rd_wdata,
  input  logic               ret_rd_we,
  input  logic [31:0]        ret_mem_addr,
  input  logic [31:0]        ret_mem_rdata,
  input  logic [31:0]        ret_mem_wdata,
  input  logic [3:0]         ret_mem_rmask,
  input  logic [3:0]         ret_mem_wmask,
  input  logic               order_load,
  input  logic [ORDER_W-1:0] order_load_val,
  output logic               pkt_valid,
  input  logic               pkt_ready,
  output rvfi_pkt_t          pkt,
  output logic               stall_req,
  output logic [CntW-1:0]    count,
  output logic               overflow
);

  logic [ORDER_W-1:0] order_q, order_d;
  logic               overflow_q, stall_q, stall_d;
  logic               push_ok, pop, full, empty;
  logic [CntW-1:0]    count_nxt;
  rvfi_pkt_t          pkt_in;

  // Capture, accept decision, next order number and next-cycle stall.
  always_comb begin
    pkt_in = rvfi_pack(OrderW'(order_q), ret_pc, ret_nxt_pc, ret_insn, ret_trap, ret_intr,
                       ret_mode, ret_rd_addr, ret_rd_wdata, ret_rd_we, ret_mem_addr,
                       ret_mem_rmask, ret_mem_wmask, ret_mem_rdata, ret_mem_wdata);
    pop     = !empty && pkt_ready;
    push_ok = ret_valid && (!full || pop);
    // Trap/interrupt entries share the number of the next retired instruction;
    // dropped packets still consume their number.
    order_d = order_q;
    if (order_load) begin
      order_d = order_load_val;
    end else if (ret_valid && !ret_trap && !ret_intr) begin
      order_d = order_q + ORDER_W'(1);
    end
    count_nxt = count + CntW'(push_ok) - CntW'(pop);
    stall_d   = (count_nxt >= CntW'(DEPTH - 1));
  end

  // Order counter, sticky overflow and registered stall request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_q    <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      order_q <= order_d;
      stall_q <= stall_d;
      if (ret_valid && !push_ok) overflow_q <= 1'b1;
    end
  end

  rv32i_sync_fifo #(
    .WIDTH($bits(rvfi_pkt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .wdata(pkt_in),
    .pop  (pop),
    .rdata(pkt),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // Output drive.
  always_comb begin
    pkt_valid = !empty;
    stall_req = stall_q;
    overflow  = overflow_q;
  end

endmodule

// File: doc/rv32i_rvfi_trace_buf.md
# rv32i_rvfi_trace_buf

Synthesizable retirement-trace buffer directly downstream of the rv32i core's retirement point. Each cycle the core retires (or traps), it captures an RVFI-style packet, stamps it with a monotonically increasing order number, and enqueues it in a small FIFO. It drains packets over a valid/ready handshake to the trace consumer (DII bridge, on-chip checker or trace port), and raises a stall request to the core before it can overflow.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- ORDER_W, 64: width of order counter and `pkt_order`.
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ret_valid  in  1  core retires or traps this cycle.
- ret_pc, ret_nxt_pc, ret_insn  in  32 each  PC, next PC (trap-adjusted), instruction (upper half zero for RVC).
- ret_trap  in  1  synchronous exception on this instruction.
- ret_intr  in  1  packet is an interrupt entry.
- ret_mode  in  2  privilege mode.
- ret_rd_addr  in  5  destination register; ret_rd_wdata  in  32  value; ret_rd_we  in  1  core writes rd.
- ret_mem_addr, ret_mem_rdata, ret_mem_wdata  in  32 each  memory access.
- ret_mem_rmask, ret_mem_wmask  in  4 each  byte masks.
- order_load  in  1  load order counter; order_load_val  in  ORDER_W  load value.
- pkt_valid  out  1  head packet available; pkt_ready  in  1  consumer accepts.
- pkt  out  rvfi_pkt_t  head packet (all fields above after sanitising, plus order).
- stall_req  out  1  core must not retire next cycle.
- count  out  $clog2(DEPTH+1)  occupancy.
- overflow  out  1  sticky; a packet was dropped.

## Operation
- Push when ret_valid and (count < DEPTH, or pop in same cycle). Otherwise packet dropped, overflow set until rst.
- Pop when pkt_valid && pkt_ready.
- Sanitising on push:
  - rd_addr/rd_wdata forced to 0 if ret_trap, !ret_rd_we, or ret_rd_addr==0.
  - mem masks forced to 0 on ret_trap.
  - `pkt.trap` = ret_trap || ret_intr.
- Order counter `order_q`, reset 0:
  - Each pushed packet carries the current `order_q`.
  - `order_q` increments by 1 after a push with !ret_trap && !ret_intr; trap/interrupt packets share the number of the next retired instruction.
  - A dropped packet still advances `order_q` (no gap hiding).
  - Wraps modulo 2^ORDER_W.
- order_load has priority over increment: `order_q` <= order_load_val. A push in the same cycle is stamped with the old value.
- stall_req = (count >= DEPTH-1), registered from next-state count, so the core sees it one cycle before full.
- States (occupancy): EMPTY (count 0, pkt_valid 0), PARTIAL, FULL (count==DEPTH).
  - Simultaneous push+pop holds count.
  - Push into FULL without pop drops.

## Timing
- Reset values: pkt_valid 0, count 0, overflow 0, stall_req 0, order_q 0, pointers 0, pkt fields 0.
- Latency: push at edge N -> pkt_valid high after edge N (visible cycle N+1). No same-cycle fall-through.
- pkt stable while pkt_valid && !pkt_ready; consumer may hold pkt_ready high continuously: sustained 1 packet/cycle.
- Reset asserted mid-operation clears contents immediately (asynchronous). Packets in flight are lost; overflow is not set.
- Pointers wrap at DEPTH (log2(DEPTH) bits); occupancy via separate count.

## Structure
- Package `rv32i_rvfi_pkg`: `rvfi_pkt_t` packed struct (order, pc, nxt_pc, insn, trap, intr, mode, rd_addr, rd_wdata, mem_addr, mem_rmask, mem_wmask, mem_rdata, mem_wdata) and a pack/sanitise function.
- Sub-module `rv32i_sync_fifo` (parameterised width/depth, async active-high rst, count output). The top holds the order counter, sanitising, stall and overflow logic.

## Test plan
- Reset, then 3 retirements (pc 0x100, 0x104, 0x108), pkt_ready=1 -> packets emerge one cycle later with order 0, 1, 2; count never exceeds 1.
- Retirement with ret_trap=1, rd_addr=5, rmask=0xF, followed by a normal retire -> trap packet order 3, rd_addr 0, rmask 0; next packet also order 3.
- pkt_ready=0, DEPTH=8, 8 retirements -> stall_req high the cycle after 7th push, count 8. A 9th retirement drops, overflow=1, `order_q` advanced to 9.
- Full FIFO, simultaneous push and pop -> count stays 8, no overflow, FIFO order preserved.
- order_load_val=0xFFFF_FFFF_FFFF_FFFF, then 2 retirements -> orders 0xFFFF_FFFF_FFFF_FFFF, then 0 (wrap).
- rst asserted asynchronously with 4 queued packets -> pkt_valid and count drop to 0 before the next clk edge; order restarts at 0.
